pipe_stage_ctrl: RTL
====================

Name: pipe_stage_ctrl

Overview:
- Parametrised N-stage valid/allow_in pipeline controller with inter-stage bus latches.
- Generalises the fixed 5-stage hand-coded valid chain of the CPU top.
- Adds selective flush: stage k kills only younger stages 0..k-1.
- Adds handshake-based input, retire pulse and performance counters. Sits between the fetch source and per-stage datapath logic in the pipelined CPU.

Parameters:
- STAGES, 5, number of pipeline stages. Index 0 is youngest (IF); STAGES-1 is oldest (WB). Legal range 2..16.
- BUS_W, 169, width of every inter-stage bus latch. Narrower buses are zero-padded by the instantiator.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  source presents a new entry for stage 0
- in_bus  in  BUS_W  payload for stage 0
- in_ready  out  1  stage 0 accepts in_bus this cycle
- stage_over  in  STAGES  bit i: stage i logic has finished its work
- flush_req  in  STAGES  bit i: stage i requests a kill of all younger stages
- stage_valid  out  STAGES  bit i: stage i holds a live entry
- stage_allow_in  out  STAGES  bit i: stage i can accept an entry
- stage_bus  out  STAGES*BUS_W  latched bus of stage i at bits [i*BUS_W +: BUS_W]
- retire  out  1  oldest stage completes this cycle
- cycle_cnt  out  CNT_W  cycles since reset
- retire_cnt  out  CNT_W  retired entries
- stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0
- flush_cnt  out  CNT_W  cycles with an effective flush

Behaviour:
- Reset (async, any time, including mid-flush):
  - stage_valid, stage_bus and all counters go to 0 immediately.
  - retire=0 while reset is held. in_ready follows its combinational equation from the cleared state.
- Effective flush:
  - eff_flush[i] = flush_req[i] & stage_valid[i]. flush_req from an invalid stage is ignored.
  - K = highest index with eff_flush set. any_flush = |eff_flush.
- Allow-in (combinational):
  - stage_allow_in[S-1] = ~v[S-1] | over[S-1].
  - For i < S-1: stage_allow_in[i] = ~v[i] | (over[i] & stage_allow_in[i+1]).
  - stage_over of an invalid stage is don't-care.
- in_ready = stage_allow_in[0] & ~any_flush. While a flush is active the input is not accepted and not consumed.
- Handoff i-1 -> i when v[i-1] & over[i-1] & stage_allow_in[i].
  - On handoff, bus[i] loads bus[i-1]. Otherwise bus[i] holds.
  - v[i] next: if stage_allow_in[i], v[i] <= v[i-1] & over[i-1] (0 if stage i-1 is killed this cycle). Otherwise v[i] holds.
- Stage 0: if stage_allow_in[0], v[0] <= in_valid & in_ready, and bus[0] loads in_bus on acceptance. Otherwise v[0] and bus[0] hold.
- Flush priority:
  - Stages 0..K-1 get v <= 0 next cycle, overriding handoff and hold.
  - Stage K and older stages advance normally. Stage K may hand off downstream in the same cycle.
  - Stage K receives nothing from K-1 that cycle: v[K] <= 0 if stage_allow_in[K] and stage K drains.
- retire = v[S-1] & over[S-1] (combinational).
- Bus latches are not cleared by flush; only valid bits are.
- Counters:
  - All wrap modulo 2^CNT_W.
  - cycle_cnt increments every cycle.
  - retire_cnt increments on retire.
  - stall_cnt increments when in_valid & ~in_ready.
  - flush_cnt increments when any_flush.
- Latency: an entry accepted at cycle t with all stages over=1 and no stalls retires at cycle t+STAGES. Throughput is one entry per cycle.
- Back-pressure: a stage stalls when over[i]=0 or the next stage has no space. Bubbles are squeezed: an invalid stage always allows in.

Test Plan:
- Reset, then in_valid=1 with in_bus=1,2,3,... and stage_over=all 1 (STAGES=5) -> first retire at cycle 5 with stage_bus[4]=1. Then one retire per cycle in order. retire_cnt=10 after 10 retires; stall_cnt=0.
- Hold stage_over[2]=0 for 3 cycles with the pipe full -> stages 0..2 hold, and in_ready=0 for those cycles. Stage 3 becomes a bubble and retires continue until drained. stall_cnt=3. Bus values are unchanged.
- Pipe full with ids 5..1, pulse flush_req[3]=1 one cycle -> next cycle stage_valid[2:0]=0, stage 4 retires id 1, stage 3 id 2 moves on. flush_cnt=1. in_ready=0 during the flush cycle.
- flush_req[2]=1 while stage 2 is invalid -> no effect, flush_cnt unchanged. flush_req[1] and flush_req[3] together -> kill is applied to stages 0..2.
- Assert reset asynchronously mid-stream between clock edges -> stage_valid=0 and counters=0 immediately, with no clock edge needed. After release, the pipe refills from stage 0.
- CNT_W=4, run 17 cycles -> cycle_cnt wraps to 1. STAGES=2 and BUS_W=8 build -> latency 2 and correct flush of stage 0 by flush_req[1].

Source files
------------

// File: rtl/pipe_stage_ctrl_if.sv
// Handshake and bus bundle for the N-stage pipeline controller.
// The master side is the fetch source plus per-stage datapath; the slave side is the controller.
interface pipe_stage_ctrl_if #(
  parameter int STAGES = 5,
  parameter int BUS_W  = 169,
  parameter int CNT_W  = 32
);
  logic                    in_valid;
  logic [BUS_W-1:0]        in_bus;
  logic                    in_ready;
  logic [STAGES-1:0]       stage_over;
  logic [STAGES-1:0]       flush_req;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES-1:0]       stage_allow_in;
  logic [STAGES*BUS_W-1:0] stage_bus;
  logic                    retire;
  logic [CNT_W-1:0]        cycle_cnt;
  logic [CNT_W-1:0]        retire_cnt;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;

  modport master (
    output in_valid, in_bus, stage_over, flush_req,
    input  in_ready, stage_valid, stage_allow_in, stage_bus, retire,
           cycle_cnt, retire_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_bus, stage_over, flush_req,
    output in_ready, stage_valid, stage_allow_in, stage_bus, retire,
           cycle_cnt, retire_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Parametrised valid/allow_in pipeline controller with inter-stage bus latches,
// selective flush of younger stages, retire pulse and performance counters.
module pipe_stage_ctrl #(
  parameter int STAGES = 5,
  parameter int BUS_W  = 169,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [STAGES-1:0]       valid;
  logic [STAGES-1:0]       valid_nxt;
  logic [STAGES-1:0]       allow;
  logic [STAGES-1:0]       eff_flush;
  logic [STAGES-1:0]       kill;
  logic [STAGES-1:0]       load;
  logic [STAGES*BUS_W-1:0] bus_q;
  logic                    any_flush;
  logic                    accept;
  logic [CNT_W-1:0]        cycle_q;
  logic [CNT_W-1:0]        retire_q;
  logic [CNT_W-1:0]        stall_q;
  logic [CNT_W-1:0]        flush_q;

  // Allow-in chain, flush kill mask and next-state of every valid bit
  always_comb begin
    eff_flush = bus.flush_req & valid;
    any_flush = |eff_flush;
    allow     = '0;
    kill      = '0;
    load      = '0;
    valid_nxt = valid;

    allow[STAGES-1] = ~valid[STAGES-1] | bus.stage_over[STAGES-1];
    kill[STAGES-1]  = 1'b0;
    // kill[i] is set when any older stage raises an effective flush
    for (int i = STAGES - 2; i >= 0; i--) begin
      allow[i] = ~valid[i] | (bus.stage_over[i] & allow[i+1]);
      kill[i]  = kill[i+1] | eff_flush[i+1];
    end

    accept  = bus.in_valid & allow[0] & ~any_flush;
    load[0] = accept;
    if (kill[0]) begin
      valid_nxt[0] = 1'b0;
    end else if (allow[0]) begin
      valid_nxt[0] = accept;
    end else begin
      valid_nxt[0] = valid[0];
    end

    // A killed upstream stage hands over nothing, even to the flushing stage
    for (int i = 1; i < STAGES; i++) begin
      load[i] = valid[i-1] & bus.stage_over[i-1] & allow[i];
      if (kill[i]) begin
        valid_nxt[i] = 1'b0;
      end else if (allow[i]) begin
        valid_nxt[i] = valid[i-1] & bus.stage_over[i-1] & ~kill[i-1];
      end else begin
        valid_nxt[i] = valid[i];
      end
    end
  end

  // Valid bits and bus latches; flush clears only valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      bus_q <= '0;
    end else begin
      valid <= valid_nxt;
      if (load[0]) begin
        bus_q[0 +: BUS_W] <= bus.in_bus;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          bus_q[i*BUS_W +: BUS_W] <= bus_q[(i-1)*BUS_W +: BUS_W];
        end
      end
    end
  end

  // Performance counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_ONE;
      if (bus.retire) begin
        retire_q <= retire_q + CNT_ONE;
      end
      if (bus.in_valid & ~bus.in_ready) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (any_flush) begin
        flush_q <= flush_q + CNT_ONE;
      end
    end
  end

  assign bus.in_ready       = allow[0] & ~any_flush;
  assign bus.stage_valid    = valid;
  assign bus.stage_allow_in = allow;
  assign bus.stage_bus      = bus_q;
  assign bus.retire         = valid[STAGES-1] & bus.stage_over[STAGES-1];
  assign bus.cycle_cnt      = cycle_q;
  assign bus.retire_cnt     = retire_q;
  assign bus.stall_cnt      = stall_q;
  assign bus.flush_cnt      = flush_q;

endmodule
